// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD calculator datapath stages: converter FSM
// states, the display driver's blank code and the BCD capacity helper.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Smallest number of decimal digits able to show 2^width-1 (width < 64).
   function automatic int min_bcd_digits(input int width);
      longint unsigned max_val;
      longint unsigned pow10;
      int              digits;
      max_val = (64'd1 << width) - 64'd1;
      pow10   = 64'd1;
      digits  = 0;
      while (pow10 <= max_val) begin
         pow10  = pow10 * 64'd10;
         digits = digits + 1;
      end
      return digits;
   endfunction

endpackage

// File: rtl/gcd_bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more so
// that the following left shift carries correctly into the next digit.
module gcd_bcd_adj3 (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   // Inputs are always 0..9 here, so the sum stays inside 4 bits.
   assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/gcd_bcd_converter.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per
// clock) fed by the GCD controller's done flag.
// Build option: define GCD_BCD_BLANK_LEADING_ZEROS_EN to replace leading zero
// digits (all but the least-significant) with the display blank code.
module gcd_bcd_converter
   import gcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  valid,
   output logic                  busy
);

   localparam int BW = 4 * DIGITS;
   localparam int SW = BW + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   // Parameter sanity: refuse to build a converter that could overflow.
   if (WIDTH < 1) begin : g_width_check
      $error("gcd_bcd_converter: WIDTH must be at least 1");
   end
   if (DIGITS < min_bcd_digits(WIDTH)) begin : g_digits_check
      $error("gcd_bcd_converter: DIGITS too small for WIDTH");
   end

   state_t          state, state_nxt;
   logic            start_q;
   logic            trigger;
   logic [SW-1:0]   shift_q, shift_nxt;
   logic [SW-1:0]   adj;
   logic [SW-1:0]   shifted;
   logic [BW-1:0]   adj_digits;
   logic [BW-1:0]   final_raw;
   logic [BW-1:0]   final_disp;
   logic [BW-1:0]   bcd_nxt;
   logic [CW-1:0]   cnt_q, cnt_nxt;
   logic            valid_nxt, busy_nxt;

   assign trigger = start & ~start_q;

   // Per-digit add-3 correction ahead of every shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      gcd_bcd_adj3 u_adj3 (
         .digit_in  (shift_q[WIDTH + 4*g +: 4]),
         .digit_out (adj_digits[4*g +: 4])
      );
   end

   assign adj       = {adj_digits, shift_q[WIDTH-1:0]};
   assign shifted   = {adj[SW-2:0], 1'b0};
   assign final_raw = shifted[SW-1:WIDTH];

   // Display formatting of the final digits before they are registered.
   always_comb begin
      final_disp = final_raw;
`ifdef GCD_BCD_BLANK_LEADING_ZEROS_EN
      begin : blank_scan
         logic leading;
         leading = 1'b1;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (final_raw[4*i +: 4] == 4'h0)) begin
               final_disp[4*i +: 4] = BCD_BLANK;
            end else begin
               leading = 1'b0;
            end
         end
      end
`endif
   end

   // Next-state and datapath control for the IDLE/CONV/HOLD sequence.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_nxt = state;
      shift_nxt = shift_q;
      cnt_nxt   = cnt_q;
      bcd_nxt   = bcd;
      valid_nxt = valid;
      busy_nxt  = busy;
      case (state)
         IDLE, HOLD: begin
            if (trigger) begin
               shift_nxt = {{BW{1'b0}}, bin};
               cnt_nxt   = CW'(WIDTH);
               busy_nxt  = 1'b1;
               valid_nxt = 1'b0;
               state_nxt = CONV;
            end
         end
         CONV: begin
            shift_nxt = shifted;
            cnt_nxt   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               bcd_nxt   = final_disp;
               valid_nxt = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = HOLD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and output registers; reset aborts any conversion.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, regardless of statement order.
      if (!reset_n) begin
         state   <= IDLE;
         start_q <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
         bcd     <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_q <= start;
         shift_q <= shift_nxt;
         cnt_q   <= cnt_nxt;
         bcd     <= bcd_nxt;
         valid   <= valid_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_gcd_bcd_converter.sv
// Directed self-checking bench for gcd_bcd_converter (WIDTH=8, DIGITS=3).
// Expected values follow the GCD_BCD_BLANK_LEADING_ZEROS_EN build option.
module tb_gcd_bcd_converter;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [WIDTH-1:0]  bin;
   logic [11:0]       bcd;
   logic              valid;
   logic              busy;

   int total = 0;
   int bad   = 0;

   gcd_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .bin     (bin),
      .bcd     (bcd),
      .valid   (valid),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of v, optionally with leading-zero blanking.
   function automatic logic [11:0] ref_bcd(input int v);
      logic [11:0] r;
      r = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef GCD_BCD_BLANK_LEADING_ZEROS_EN
      if (r[11:8] == 4'h0) begin
         r[11:8] = 4'hF;
         if (r[7:4] == 4'h0) r[7:4] = 4'hF;
      end
`endif
      return r;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Called one negedge after the load edge: busy for WIDTH samples, then result.
   task automatic wait_result(input string tag, input logic [11:0] exp);
      for (int i = 0; i < WIDTH; i++) begin
         check({tag, "_busy"}, {30'd0, busy, valid}, 32'b10);
         step();
      end
      check({tag, "_done"}, {30'd0, busy, valid}, 32'b01);
      check({tag, "_bcd"}, {20'd0, bcd}, {20'd0, exp});
   endtask

   task automatic convert(input string tag, input logic [WIDTH-1:0] v, input logic [11:0] exp);
      bin   = v;
      start = 1'b1;
      step();
      start = 1'b0;
      bin   = ~v;
      wait_result(tag, exp);
   endtask

   initial begin
      int rises;
      logic prev_busy;
      reset_n = 1'b0;
      start   = 1'b0;
      bin     = '0;
      step();
      step();
      check("reset_bcd", {20'd0, bcd}, 32'd0);
      check("reset_flags", {30'd0, busy, valid}, 32'd0);
      reset_n = 1'b1;
      step();
      check("idle_flags", {30'd0, busy, valid}, 32'd0);

      convert("bin6", 8'd6, ref_bcd(6));
      check("bin6_lit", {20'd0, ref_bcd(6)}, {20'd0,
`ifdef GCD_BCD_BLANK_LEADING_ZEROS_EN
         12'hFF6
`else
         12'h006
`endif
      });
      convert("bin255", 8'd255, 12'h255);
      convert("bin0", 8'd0,
`ifdef GCD_BCD_BLANK_LEADING_ZEROS_EN
         12'hFF0
`else
         12'h000
`endif
      );
      // Held result must not change while idle in HOLD.
      step();
      step();
      check("hold_bcd", {20'd0, bcd}, {20'd0, ref_bcd(0)});
      check("hold_flags", {30'd0, busy, valid}, 32'b01);

      // Level held high for 50 cycles: exactly one conversion.
      bin   = 8'd100;
      start = 1'b1;
      rises = 0;
      prev_busy = busy;
      for (int i = 0; i < 50; i++) begin
         step();
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
         bin = 8'd77;
      end
      check("level_rises", rises, 32'd1);
      check("level_bcd", {20'd0, bcd}, 32'h100);
      check("level_flags", {30'd0, busy, valid}, 32'b01);
      start = 1'b0;
      step();
      convert("b2b21", 8'd21, ref_bcd(21));

      // Extra pulse in the 4th CONV cycle with bin changing: ignored.
      bin   = 8'd137;
      start = 1'b1;
      step();
      start = 1'b0;
      bin   = 8'd42;
      for (int i = 0; i < 3; i++) begin
         check("extra_busy_pre", {30'd0, busy, valid}, 32'b10);
         step();
      end
      start = 1'b1;
      bin   = 8'd99;
      check("extra_busy_pulse", {30'd0, busy, valid}, 32'b10);
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("extra_busy_post", {30'd0, busy, valid}, 32'b10);
         step();
      end
      check("extra_done", {30'd0, busy, valid}, 32'b01);
      check("extra_bcd", {20'd0, bcd}, 32'h137);
      step();
      step();
      check("extra_no_retrig", {30'd0, busy, valid}, 32'b01);

      // Reset in the 5th CONV cycle, then restart with start still high.
      bin   = 8'd200;
      start = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         check("rst_busy_pre", {30'd0, busy, valid}, 32'b10);
         step();
      end
      reset_n = 1'b0;
      #1;
      check("rst_abort_bcd", {20'd0, bcd}, 32'd0);
      check("rst_abort_flags", {30'd0, busy, valid}, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      start = 1'b0;
      wait_result("rst_restart", 12'h200);

      // Sweep every input value against the reference model.
      for (int v = 0; v < 256; v++) begin
         logic ok;
         convert("sweep", 8'(v), ref_bcd(v));
         ok = 1'b1;
         for (int d = 0; d < 3; d++) begin
            logic [11:0] cur;
            cur = bcd;
            if (cur[4*d +: 4] > 4'd9 && cur[4*d +: 4] != 4'hF) ok = 1'b0;
         end
         check("sweep_digit_range", {31'd0, ok}, 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
